toysram_32x12_ctl: RTL and testbench
====================================

# toysram_32x12_ctl

Synchronous port controller that drives one 32x12 toysram subarray from the clocked domain. It accepts two independent read ports and one write port. It decodes addresses into registered one-hot read wordlines (RWL0/RWL1), sequences the write bitline/wordline pulse (WBL/WBLb/WWL), and captures the read bitlines (RBL0/RBL1) into registered read data. It sits directly between the array macro and the core-side request logic.

## Interface
- WPULSE, 1: WWL high time in cycles; legal range 1-4.
- RBL_INV, 0: 1 = invert RBL0/RBL1 on capture (array reads active-low); 0 = capture as-is.

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- r0_req  in  1  read port 0 request
- r0_addr  in  5  read port 0 word address
- r0_gnt  out  1  read port 0 accepted this cycle (combinational)
- r0_vld  out  1  read port 0 data valid
- r0_data  out  12  read port 0 data, bit 0 = RBL0[0]
- r1_req / r1_addr / r1_gnt / r1_vld / r1_data: same as port 0, using RWL1/RBL1
- w_req  in  1  write request
- w_addr  in  5  write word address
- w_data  in  12  write data, bit 0 → WBL[0]
- w_gnt  out  1  write accepted this cycle (combinational)
- RWL0, RWL1  out  [0:31]  read wordlines; address a drives bit a
- WWL  out  [0:31]  write wordlines
- WBL, WBLb  out  [0:11]  write bitline pair
- RBL0, RBL1  in  [0:11]  read bitlines from array

## Operation
- **Reads.** The two ports are fully independent and pipelined, accepting one read per port per cycle.
  - r*_gnt = r*_req & ~hazard.
  - The registered one-hot wordline goes high in the cycle after the grant.
  - RBL is captured at the end of that cycle.
- **Read hazard.** A read is refused (gnt=0) if its address equals:
  - the address of a write in SETUP, PULSE or HOLD, or
  - w_addr of a write granted in the same cycle.
- **Same-address reads.** Both ports reading the same address in the same cycle is legal.
- **Write FSM states.** IDLE → SETUP → PULSE (WPULSE cycles) → HOLD → IDLE.
  - IDLE: w_gnt = w_req. Latch w_addr/w_data on grant and go to SETUP. WBL = WBLb = 0, WWL = 0.
  - SETUP: WBL = data, WBLb = ~data, WWL = 0.
  - PULSE: bitlines held; WWL[addr] = 1; a counter counts WPULSE cycles.
  - HOLD: WWL = 0, bitlines held; next state IDLE.
  - w_gnt = 0 in every state except IDLE.
  - Write throughput is one write per WPULSE+3 cycles.
- **Same-cycle read/write to one address.** The write is granted and the read stalls. Same-cycle read and write to different addresses both proceed.
- **One-hot invariants.** At most one RWL0 bit, one RWL1 bit and one WWL bit is high at any time. WWL is never high while the bitlines change.
- **Reset.** Asserting rst_n low mid-operation takes effect asynchronously:
  - all wordlines, bitlines, gnt-related state, vld and data are cleared to 0;
  - the FSM returns to IDLE;
  - any in-flight read or write is dropped. A partially pulsed write leaves the array contents undefined.
- Reset value of every output is 0. r*_gnt and w_gnt are 0 while in reset.

## Timing
- **Read.** Grant at edge T.
  - Cycle T+1: RWLp[a] = 1 for exactly one cycle, unless the port is granted again at T+1.
  - Edge T+2: r*_data = RBL sampled at that edge (XOR RBL_INV), and r*_vld = 1.
  - Read latency is 2 cycles.
  - Back-to-back reads move the wordline each cycle and produce vld on consecutive cycles.
  - An idle port drives RWL = 0 and vld = 0. r*_data holds its last value when vld = 0.
- **Write.** Grant at edge T.
  - Cycle T+1: SETUP.
  - Cycles T+2 .. T+1+WPULSE: WWL high.
  - Cycle T+2+WPULSE: HOLD.
  - IDLE (w_gnt possible) from T+3+WPULSE.
- **Read-after-write ordering.** A read of the written address is granted no earlier than the IDLE cycle. It therefore returns the new data.

## Test plan
- Reset, then write addr 5 = 0xA5C with WPULSE=1 → SETUP at T+1 with WBL=0xA5C, WBLb=0x5A3; WWL[5] high only at T+2; HOLD at T+3; w_gnt high again at T+4.
- Preload the array model; on port 0 read addresses 0,1,31 back-to-back → RWL0 one-hot 0,1,31 on consecutive cycles; r0_vld high for 3 consecutive cycles starting 2 cycles after the first grant, carrying the correct data.
- Write addr 7 while r1_req addr 7 in the same cycle → w_gnt=1, r1_gnt=0 through SETUP/PULSE/HOLD; r1 granted in the IDLE cycle and returns the new data.
- Port 0 reads addr 3 while port 1 reads addr 3 and a write targets addr 9 → all three granted; both read ports return the same data; WWL[9] pulses.
- WPULSE=4 with RBL_INV=1: WWL high for exactly 4 cycles; read data equals ~RBL.
- Drop rst_n in the middle of PULSE → WWL, WBL, WBLb, RWL and vld go to 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and w_gnt follows w_req.

Source files
------------

// File: rtl/toysram_32x12_ctl.sv
// Port controller for one 32x12 toysram subarray: two pipelined read ports
// with registered one-hot wordlines, and a sequenced write (setup/pulse/hold).
module toysram_32x12_ctl #(
    parameter int unsigned WPULSE  = 1,
    parameter bit          RBL_INV = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic [4:0]  r0_addr,
    output logic        r0_gnt,
    output logic        r0_vld,
    output logic [11:0] r0_data,
    input  logic        r1_req,
    input  logic [4:0]  r1_addr,
    output logic        r1_gnt,
    output logic        r1_vld,
    output logic [11:0] r1_data,
    input  logic        w_req,
    input  logic [4:0]  w_addr,
    input  logic [11:0] w_data,
    output logic        w_gnt,
    output logic [0:31] RWL0,
    output logic [0:31] RWL1,
    output logic [0:31] WWL,
    output logic [0:11] WBL,
    output logic [0:11] WBLb,
    input  logic [0:11] RBL0,
    input  logic [0:11] RBL1
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 12;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 2;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [NW-1:0] wwl_q, wwl_d;
    logic [DW-1:0] wbl_q, wbl_d, wblb_q, wblb_d;
    logic [NW-1:0] rwl0_q, rwl0_d, rwl1_q, rwl1_d;
    logic          vld0_q, vld0_d, vld1_q, vld1_d;
    logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [DW-1:0] rbl0_w, rbl1_w;
    logic          wr_busy, hz0, hz1;

    // Grants are gated by rst_n so they read 0 throughout reset.
    assign wr_busy = (state_q != S_IDLE);
    assign w_gnt   = rst_n & ~wr_busy & w_req;
    assign hz0     = (wr_busy && (r0_addr == wa_q)) || (w_gnt && (r0_addr == w_addr));
    assign hz1     = (wr_busy && (r1_addr == wa_q)) || (w_gnt && (r1_addr == w_addr));
    assign r0_gnt  = rst_n & r0_req & ~hz0;
    assign r1_gnt  = rst_n & r1_req & ~hz1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            wwl_q   <= '0;
            wbl_q   <= '0;
            wblb_q  <= '0;
            rwl0_q  <= '0;
            rwl1_q  <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            data0_q <= '0;
            data1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wwl_q   <= wwl_d;
            wbl_q   <= wbl_d;
            wblb_q  <= wblb_d;
            rwl0_q  <= rwl0_d;
            rwl1_q  <= rwl1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
        end
    end

    // Write sequencer next state; address/data latched on grant.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_gnt) begin
                    state_d = S_SETUP;
                    wa_d    = w_addr;
                    wd_d    = w_data;
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = '0;
            end
            S_PULSE: begin
                if (cnt_q == CW'(WPULSE - 1)) state_d = S_HOLD;
                else                          cnt_d   = cnt_q + CW'(1);
            end
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs derived from the next state, so bitlines only move while WWL is low.
    always_comb begin
        wwl_d  = '0;
        wbl_d  = '0;
        wblb_d = '0;
        if (state_d != S_IDLE) begin
            wbl_d  = wd_d;
            wblb_d = ~wd_d;
        end
        if (state_d == S_PULSE) wwl_d[wa_d] = 1'b1;

        rwl0_d = '0;
        rwl1_d = '0;
        if (r0_gnt) rwl0_d[r0_addr] = 1'b1;
        if (r1_gnt) rwl1_d[r1_addr] = 1'b1;

        vld0_d  = |rwl0_q;
        vld1_d  = |rwl1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        if (vld0_d) data0_d = rbl0_w ^ {DW{RBL_INV}};
        if (vld1_d) data1_d = rbl1_w ^ {DW{RBL_INV}};
    end

    // Array-side buses are ascending; map index-for-index to internal vectors.
    always_comb begin
        for (int i = 0; i < int'(DW); i++) begin
            rbl0_w[i] = RBL0[i];
            rbl1_w[i] = RBL1[i];
            WBL[i]    = wbl_q[i];
            WBLb[i]   = wblb_q[i];
        end
        for (int i = 0; i < int'(NW); i++) begin
            RWL0[i] = rwl0_q[i];
            RWL1[i] = rwl1_q[i];
            WWL[i]  = wwl_q[i];
        end
    end

    assign r0_vld  = vld0_q;
    assign r1_vld  = vld1_q;
    assign r0_data = data0_q;
    assign r1_data = data1_q;

endmodule

// File: tb/tb_toysram_32x12_ctl.sv
// Directed bench: instance a (WPULSE=1, plain RBL) and instance b (WPULSE=4, inverted RBL)
// each attached to a small behavioural array model.
module tb_toysram_32x12_ctl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wl(input logic [0:31] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [11:0] bl(input logic [0:11] v);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) r[i] = v[i];
        return r;
    endfunction

    // instance a signals
    logic        r0_req_a = 0, r1_req_a = 0, w_req_a = 0;
    logic [4:0]  r0_addr_a = 0, r1_addr_a = 0, w_addr_a = 0;
    logic [11:0] w_data_a = 0;
    logic        r0_gnt_a, r1_gnt_a, w_gnt_a, r0_vld_a, r1_vld_a;
    logic [11:0] r0_data_a, r1_data_a;
    logic [0:31] rwl0_a, rwl1_a, wwl_a;
    logic [0:11] wbl_a, wblb_a, rbl0_a, rbl1_a;

    // instance b signals
    logic        r0_req_b = 0, r1_req_b = 0, w_req_b = 0;
    logic [4:0]  r0_addr_b = 0, r1_addr_b = 0, w_addr_b = 0;
    logic [11:0] w_data_b = 0;
    logic        r0_gnt_b, r1_gnt_b, w_gnt_b, r0_vld_b, r1_vld_b;
    logic [11:0] r0_data_b, r1_data_b;
    logic [0:31] rwl0_b, rwl1_b, wwl_b;
    logic [0:11] wbl_b, wblb_b, rbl0_b, rbl1_b;

    toysram_32x12_ctl #(.WPULSE(1), .RBL_INV(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req_a), .r0_addr(r0_addr_a), .r0_gnt(r0_gnt_a), .r0_vld(r0_vld_a), .r0_data(r0_data_a),
        .r1_req(r1_req_a), .r1_addr(r1_addr_a), .r1_gnt(r1_gnt_a), .r1_vld(r1_vld_a), .r1_data(r1_data_a),
        .w_req(w_req_a), .w_addr(w_addr_a), .w_data(w_data_a), .w_gnt(w_gnt_a),
        .RWL0(rwl0_a), .RWL1(rwl1_a), .WWL(wwl_a), .WBL(wbl_a), .WBLb(wblb_a),
        .RBL0(rbl0_a), .RBL1(rbl1_a)
    );

    toysram_32x12_ctl #(.WPULSE(4), .RBL_INV(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req_b), .r0_addr(r0_addr_b), .r0_gnt(r0_gnt_b), .r0_vld(r0_vld_b), .r0_data(r0_data_b),
        .r1_req(r1_req_b), .r1_addr(r1_addr_b), .r1_gnt(r1_gnt_b), .r1_vld(r1_vld_b), .r1_data(r1_data_b),
        .w_req(w_req_b), .w_addr(w_addr_b), .w_data(w_data_b), .w_gnt(w_gnt_b),
        .RWL0(rwl0_b), .RWL1(rwl1_b), .WWL(wwl_b), .WBL(wbl_b), .WBLb(wblb_b),
        .RBL0(rbl0_b), .RBL1(rbl1_b)
    );

    // Array models: write on clock edge while a WWL row is high; preload port for the bench.
    logic [11:0] mem_a [32];
    logic [11:0] mem_b [32];
    logic        pl_en = 0;
    logic [4:0]  pl_addr = 0;
    logic [11:0] pl_data = 0;

    always @(posedge clk) begin
        if (pl_en) mem_a[pl_addr] <= pl_data;
        for (int a = 0; a < 32; a++) begin
            if (wwl_a[a]) mem_a[a] <= bl(wbl_a);
            if (wwl_b[a]) mem_b[a] <= bl(wbl_b);
        end
    end

    always_comb begin
        logic [11:0] s0a, s1a, s0b, s1b;
        s0a = '0; s1a = '0; s0b = '0; s1b = '0;
        for (int a = 0; a < 32; a++) begin
            if (rwl0_a[a]) s0a |= mem_a[a];
            if (rwl1_a[a]) s1a |= mem_a[a];
            if (rwl0_b[a]) s0b |= mem_b[a];
            if (rwl1_b[a]) s1b |= mem_b[a];
        end
        for (int i = 0; i < 12; i++) begin
            rbl0_a[i] = s0a[i];
            rbl1_a[i] = s1a[i];
            rbl0_b[i] = ~s0b[i];
            rbl1_b[i] = ~s1b[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] a, input logic [11:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 0;
    endtask

    initial begin
        // reset state
        w_req_a = 1; r0_req_a = 1;
        #2;
        check("rst_w_gnt", 32'(w_gnt_a), 32'h0);
        check("rst_r0_gnt", 32'(r0_gnt_a), 32'h0);
        check("rst_wwl", wl(wwl_a), 32'h0);
        check("rst_wbl", 32'(bl(wbl_a)), 32'h0);
        check("rst_rwl0", wl(rwl0_a), 32'h0);
        check("rst_vld", 32'({r0_vld_a, r1_vld_a}), 32'h0);
        check("rst_data", 32'(r0_data_a), 32'h0);
        w_req_a = 0; r0_req_a = 0;
        @(negedge clk);
        rst_n = 1;
        tick();

        // write addr 5 = 0xA5C, WPULSE=1
        w_req_a = 1; w_addr_a = 5; w_data_a = 12'hA5C;
        #1 check("wr_gnt_T", 32'(w_gnt_a), 32'h1);
        tick();
        check("setup_wbl", 32'(bl(wbl_a)), 32'hA5C);
        check("setup_wblb", 32'(bl(wblb_a)), 32'h5A3);
        check("setup_wwl", wl(wwl_a), 32'h0);
        check("setup_gnt", 32'(w_gnt_a), 32'h0);
        tick();
        check("pulse_wwl", wl(wwl_a), 32'h1 << 5);
        check("pulse_wbl", 32'(bl(wbl_a)), 32'hA5C);
        tick();
        check("hold_wwl", wl(wwl_a), 32'h0);
        check("hold_wblb", 32'(bl(wblb_a)), 32'h5A3);
        check("hold_gnt", 32'(w_gnt_a), 32'h0);
        tick();
        check("idle_gnt", 32'(w_gnt_a), 32'h1);
        check("idle_wbl", 32'(bl(wbl_a)), 32'h0);
        w_req_a = 0;
        tick();
        check("mem5", 32'(mem_a[5]), 32'hA5C);

        // back-to-back reads 0,1,31 on port 0
        preload(0, 12'h123);
        preload(1, 12'h456);
        preload(31, 12'hFED);
        r0_req_a = 1; r0_addr_a = 0;
        #1 check("rd_gnt0", 32'(r0_gnt_a), 32'h1);
        tick();
        check("rwl_0", wl(rwl0_a), 32'h1);
        check("rd_vld_c1", 32'(r0_vld_a), 32'h0);
        r0_addr_a = 1;
        tick();
        check("rwl_1", wl(rwl0_a), 32'h2);
        check("rd_vld_0", 32'(r0_vld_a), 32'h1);
        check("rd_data_0", 32'(r0_data_a), 32'h123);
        r0_addr_a = 31;
        tick();
        check("rwl_31", wl(rwl0_a), 32'h8000_0000);
        check("rd_data_1", 32'(r0_data_a), 32'h456);
        r0_req_a = 0;
        tick();
        check("rwl_idle", wl(rwl0_a), 32'h0);
        check("rd_vld_31", 32'(r0_vld_a), 32'h1);
        check("rd_data_31", 32'(r0_data_a), 32'hFED);
        tick();
        check("rd_vld_off", 32'(r0_vld_a), 32'h0);
        check("rd_data_hold", 32'(r0_data_a), 32'hFED);

        // write addr 7 with same-cycle read of addr 7 on port 1
        preload(7, 12'h111);
        w_req_a = 1; w_addr_a = 7; w_data_a = 12'h7E1;
        r1_req_a = 1; r1_addr_a = 7;
        #1;
        check("haz_w_gnt", 32'(w_gnt_a), 32'h1);
        check("haz_r1_gnt", 32'(r1_gnt_a), 32'h0);
        tick();
        w_req_a = 0;
        #1 check("haz_setup", 32'(r1_gnt_a), 32'h0);
        tick();
        check("haz_pulse", 32'(r1_gnt_a), 32'h0);
        tick();
        check("haz_hold", 32'(r1_gnt_a), 32'h0);
        tick();
        check("haz_idle", 32'(r1_gnt_a), 32'h1);
        tick();
        r1_req_a = 0;
        check("haz_rwl1", wl(rwl1_a), 32'h1 << 7);
        tick();
        check("haz_vld", 32'(r1_vld_a), 32'h1);
        check("haz_data", 32'(r1_data_a), 32'h7E1);

        // dual read of addr 3 while writing addr 9
        preload(3, 12'hBEE);
        r0_req_a = 1; r0_addr_a = 3; r1_req_a = 1; r1_addr_a = 3;
        w_req_a = 1; w_addr_a = 9; w_data_a = 12'h3C9;
        #1;
        check("tri_r0", 32'(r0_gnt_a), 32'h1);
        check("tri_r1", 32'(r1_gnt_a), 32'h1);
        check("tri_w", 32'(w_gnt_a), 32'h1);
        tick();
        r0_req_a = 0; r1_req_a = 0; w_req_a = 0;
        check("tri_rwl0", wl(rwl0_a), 32'h1 << 3);
        check("tri_rwl1", wl(rwl1_a), 32'h1 << 3);
        tick();
        check("tri_wwl", wl(wwl_a), 32'h1 << 9);
        check("tri_d0", 32'(r0_data_a), 32'hBEE);
        check("tri_d1", 32'(r1_data_a), 32'hBEE);
        tick();
        check("tri_hold", wl(wwl_a), 32'h0);
        tick();
        check("mem9", 32'(mem_a[9]), 32'h3C9);

        // WPULSE=4 with inverted read bitlines
        w_req_b = 1; w_addr_b = 12; w_data_b = 12'h5A5;
        #1 check("b_w_gnt", 32'(w_gnt_b), 32'h1);
        tick();
        w_req_b = 0;
        check("b_setup_wwl", wl(wwl_b), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b_pulse%0d", i), wl(wwl_b), 32'h1 << 12);
        end
        tick();
        check("b_hold_wwl", wl(wwl_b), 32'h0);
        check("b_hold_gnt", 32'(r0_gnt_b), 32'h0);
        tick();
        r0_req_b = 1; r0_addr_b = 12;
        #1 check("b_rd_gnt", 32'(r0_gnt_b), 32'h1);
        tick();
        r0_req_b = 0;
        tick();
        check("b_rd_vld", 32'(r0_vld_b), 32'h1);
        check("b_rd_data", 32'(r0_data_b), 32'h5A5);

        // asynchronous reset in the middle of PULSE
        preload(2, 12'h2AA);
        r0_req_a = 1; r0_addr_a = 2;
        w_req_b = 1; w_addr_b = 20; w_data_b = 12'hC3C;
        tick();
        w_req_b = 0;
        tick();
        check("ar_pre_wwl", wl(wwl_b), 32'h1 << 20);
        check("ar_pre_vld", 32'(r0_vld_a), 32'h1);
        #3 rst_n = 0;
        #1;
        check("ar_wwl", wl(wwl_b), 32'h0);
        check("ar_wbl", 32'(bl(wbl_b)), 32'h0);
        check("ar_wblb", 32'(bl(wblb_b)), 32'h0);
        check("ar_rwl0", wl(rwl0_a), 32'h0);
        check("ar_vld", 32'(r0_vld_a), 32'h0);
        check("ar_data", 32'(r0_data_a), 32'h0);
        r0_req_a = 0;
        tick();
        @(negedge clk);
        rst_n = 1;
        w_req_b = 1; w_addr_b = 4; w_data_b = 12'h0F0;
        #1 check("ar_idle_gnt", 32'(w_gnt_b), 32'h1);
        tick();
        w_req_b = 0;
        check("ar_setup_wbl", 32'(bl(wbl_b)), 32'h0F0);
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
